// File: rtl/sm_mcu_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters (Nios data, TFT DMA), the arbiter and the shared RAM.
// slave: arbiter side. master: the surrounding masters plus the RAM.
interface sm_mcu_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/sm_mcu_mem_arbiter.sv
// Two-master arbiter for the shared 1024x32 RAM: round-robin with MAX_GRANT bounded ownership,
// or strict m0 priority when MEM_ARB_FIXED_PRIO_EN is defined.
module sm_mcu_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_GRANT = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    sm_mcu_mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

    logic [1:0]             rd, wr, req;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][BE_W-1:0]   be;
    logic [1:0][DATA_W-1:0] wdata;

    assign rd    = {bus.m1_read, bus.m0_read};
    assign wr    = {bus.m1_write, bus.m0_write};
    assign req   = rd | wr;
    assign addr  = {bus.m1_address, bus.m0_address};
    assign be    = {bus.m1_byteenable, bus.m0_byteenable};
    assign wdata = {bus.m1_writedata, bus.m0_writedata};

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;

    logic gnt_vld, gnt_sel, gnt, keep, mux_sel;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin : arb
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (req[0]) begin
            gnt_vld = 1'b1;
        end else if (req[1]) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b1;
        end
    end
`else
    localparam logic [7:0] MAX_GRANT_C = 8'(MAX_GRANT);
    logic own;

    always_comb begin : arb
        own     = (state_q == OWN1);
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        case (state_q)
            OWN0, OWN1: begin
                // Owner keeps the port until its quota runs out, but only if the other side wants it.
                if (req[own] && (cnt_q < MAX_GRANT_C || !req[~own])) begin
                    gnt_vld = 1'b1;
                    gnt_sel = own;
                end else if (req[~own]) begin
                    gnt_vld = 1'b1;
                    gnt_sel = ~own;
                end
            end
            default: begin
                if (&req) begin
                    gnt_vld = 1'b1;
                    gnt_sel = ~last_q;
                end else if (req[0]) begin
                    gnt_vld = 1'b1;
                end else if (req[1]) begin
                    gnt_vld = 1'b1;
                    gnt_sel = 1'b1;
                end
            end
        endcase
    end
`endif

    assign gnt     = gnt_vld & reset_n;
    assign keep    = (state_q == OWN0 && !gnt_sel) || (state_q == OWN1 && gnt_sel);
    assign mux_sel = gnt & gnt_sel;

    always_comb begin : nxt
        state_d    = IDLE;
        cnt_d      = '0;
        last_d     = last_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        if (gnt_vld) begin
            state_d    = gnt_sel ? OWN1 : OWN0;
            cnt_d      = !keep ? 8'd1 : (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            last_d     = gnt_sel;
            // A combined read+write executes as a write only; no data comes back.
            rd_pend_d  = rd[gnt_sel] & ~wr[gnt_sel];
            rd_owner_d = gnt_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // With no grant the RAM bus idles on m0's fields, only chipselect/write drop.
    assign bus.mem_address    = addr[mux_sel];
    assign bus.mem_byteenable = be[mux_sel];
    assign bus.mem_writedata  = wdata[mux_sel];
    assign bus.mem_chipselect = gnt;
    assign bus.mem_write      = gnt & wr[gnt_sel];
    assign bus.mem_clken      = reset_n;

    assign bus.m0_waitrequest = ~reset_n | (req[0] & ~(gnt & ~gnt_sel));
    assign bus.m1_waitrequest = ~reset_n | (req[1] & ~(gnt & gnt_sel));

    // Gating with reset_n drops a return whose reset lands in the return cycle.
    assign bus.m0_readdatavalid = reset_n & rd_pend_q & ~rd_owner_q;
    assign bus.m1_readdatavalid = reset_n & rd_pend_q & rd_owner_q;
    assign bus.m0_readdata      = bus.mem_readdata;
    assign bus.m1_readdata      = bus.mem_readdata;
endmodule

// File: tb/tb_sm_mcu_mem_arbiter.sv
// Bench for sm_mcu_mem_arbiter: directed scenarios plus a randomized run against a grant/memory model.
module tb_sm_mcu_mem_arbiter;
    localparam int ADDR_W = 10, DATA_W = 32, BE_W = 4, MAX_GRANT = 8, DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    bit   load_mem = 1'b1;
    int   n_vec = 0, n_err = 0;

    sm_mcu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    sm_mcu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_GRANT(MAX_GRANT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 1023) return 32'h11223344;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // RAM stand-in: registered address, unregistered data, byte-enabled writes, frozen when clken=0
    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (bus.mem_clken && bus.mem_chipselect) begin
            ram_addr_q <= bus.mem_address;
            if (bus.mem_write)
                for (int b = 0; b < BE_W; b++)
                    if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
        end
    end
    assign bus.mem_readdata = ram[ram_addr_q];

    // Reference model: who was granted last cycle, how many times in a row, and who won most recently
    int          prev_gnt = -1, run = 0, exp_gnt;
    bit          last_g = 1'b1, pend = 1'b0, pend_who = 1'b0;
    logic [31:0] pend_data = '0;
    logic [31:0] gmem [DEPTH];
    bit          r0, r1, exp_w0, exp_w1, exp_cs, exp_we, exp_rdv0, exp_rdv1, sel_rd, sel_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;

    always_comb begin
        r0 = bus.m0_read | bus.m0_write;
        r1 = bus.m1_read | bus.m1_write;
        exp_gnt = -1;
        if (reset_n) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            if (r0) exp_gnt = 0;
            else if (r1) exp_gnt = 1;
`else
            if (r0 && r1) exp_gnt = (prev_gnt >= 0 && run < MAX_GRANT) ? prev_gnt : (last_g ? 0 : 1);
            else if (r0) exp_gnt = 0;
            else if (r1) exp_gnt = 1;
`endif
        end
        exp_w0   = !reset_n || (r0 && exp_gnt != 0);
        exp_w1   = !reset_n || (r1 && exp_gnt != 1);
        exp_cs   = (exp_gnt >= 0);
        sel_rd   = (exp_gnt == 1) ? bus.m1_read : bus.m0_read;
        sel_wr   = (exp_gnt == 1) ? bus.m1_write : bus.m0_write;
        exp_addr = (exp_gnt == 1) ? bus.m1_address : bus.m0_address;
        sel_be   = (exp_gnt == 1) ? bus.m1_byteenable : bus.m0_byteenable;
        sel_wd   = (exp_gnt == 1) ? bus.m1_writedata : bus.m0_writedata;
        exp_we   = exp_cs && sel_wr;
        exp_rdv0 = reset_n && pend && !pend_who;
        exp_rdv1 = reset_n && pend && pend_who;
    end

    always @(posedge clk) begin
        if (load_mem)
            for (int i = 0; i < DEPTH; i++) gmem[i] <= init_word(i);
        if (!reset_n) begin
            prev_gnt <= -1; run <= 0; last_g <= 1'b1; pend <= 1'b0;
        end else if (exp_gnt >= 0) begin
            run      <= (exp_gnt == prev_gnt) ? run + 1 : 1;
            prev_gnt <= exp_gnt;
            last_g   <= exp_gnt[0];
            if (sel_wr)
                for (int b = 0; b < BE_W; b++)
                    if (sel_be[b]) gmem[exp_addr][8*b +: 8] <= sel_wd[8*b +: 8];
            pend      <= sel_rd && !sel_wr;
            pend_who  <= exp_gnt[0];
            pend_data <= gmem[exp_addr];
        end else begin
            prev_gnt <= -1; run <= 0; pend <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        bus.m0_read = 0; bus.m0_write = 0; bus.m1_read = 0; bus.m1_write = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; load_mem = 1;
        bus.m0_address = 10'h000; bus.m1_address = 10'h001;
        bus.m0_byteenable = 4'hF; bus.m1_byteenable = 4'hF;
        bus.m0_writedata = '0; bus.m1_writedata = '0;
        bus.m0_write = 0; bus.m1_write = 0; bus.m0_read = 1; bus.m1_read = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++; if (bus.m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m0_wait got %b want 1", bus.m0_waitrequest); end
            n_vec++; if (bus.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m1_wait got %b want 1", bus.m1_waitrequest); end
            n_vec++; if (bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0) begin n_err++; $display("FAIL rst_cs got cs=%b we=%b want 0", bus.mem_chipselect, bus.mem_write); end
            n_vec++; if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_rdv got %b%b want 00", bus.m0_readdatavalid, bus.m1_readdatavalid); end
            n_vec++; if (bus.mem_clken !== 1'b0) begin n_err++; $display("FAIL rst_clken got %b want 0", bus.mem_clken); end
            tick();
        end
        load_mem = 0; reset_n = 1;
        @(negedge clk);
        n_vec++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL first_tie got w0=%b w1=%b want w0=0 w1=1", bus.m0_waitrequest, bus.m1_waitrequest); end
        n_vec++; if (bus.mem_chipselect !== 1'b1 || bus.mem_address !== 10'h000) begin n_err++; $display("FAIL first_tie_bus got cs=%b a=%h want cs=1 a=000", bus.mem_chipselect, bus.mem_address); end
        tick(); idle_inputs();
        @(negedge clk);
        n_vec++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== init_word(0)) begin n_err++; $display("FAIL first_read got v=%b d=%h want v=1 d=%h", bus.m0_readdatavalid, bus.m0_readdata, init_word(0)); end
        tick();
    endtask

    task automatic test_single_read();
        idle_inputs(); tick();
        bus.m1_read = 1; bus.m1_address = 10'h005;
        @(negedge clk);
        n_vec++; if (bus.m1_waitrequest !== 1'b0 || bus.mem_address !== 10'h005) begin n_err++; $display("FAIL sread_issue got w1=%b a=%h want w1=0 a=005", bus.m1_waitrequest, bus.mem_address); end
        tick(); bus.m1_read = 0;
        @(negedge clk);
        n_vec++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sread_data got v=%b d=%h want v=1 d=deadbeef", bus.m1_readdatavalid, bus.m1_readdata); end
        n_vec++; if (bus.m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL sread_m0v got %b want 0", bus.m0_readdatavalid); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL sread_oneshot got %b want 0", bus.m1_readdatavalid); end
        tick();
    endtask

    task automatic test_byte_write();
        bus.m0_write = 1; bus.m0_address = 10'h3FF; bus.m0_byteenable = 4'b0010; bus.m0_writedata = 32'h0000AB00;
        @(negedge clk);
        n_vec++; if (bus.mem_write !== 1'b1 || bus.mem_byteenable !== 4'b0010) begin n_err++; $display("FAIL bwr_issue got we=%b be=%b want we=1 be=0010", bus.mem_write, bus.mem_byteenable); end
        tick(); bus.m0_write = 0; bus.m0_read = 1; bus.m0_byteenable = 4'hF;
        tick(); bus.m0_read = 0;
        @(negedge clk);
        n_vec++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'h1122AB44) begin n_err++; $display("FAIL bwr_readback got v=%b d=%h want v=1 d=1122ab44", bus.m0_readdatavalid, bus.m0_readdata); end
        tick();
    endtask

    task automatic test_rw_same();
        bus.m0_read = 1; bus.m0_write = 1; bus.m0_address = 10'h010; bus.m0_byteenable = 4'hF; bus.m0_writedata = 32'h55AA55AA;
        @(negedge clk);
        n_vec++; if (bus.mem_write !== 1'b1) begin n_err++; $display("FAIL rw_write got %b want 1", bus.mem_write); end
        tick(); idle_inputs();
        @(negedge clk);
        n_vec++; if (bus.m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rw_no_rdv got %b want 0", bus.m0_readdatavalid); end
        tick(); bus.m0_read = 1;
        tick(); bus.m0_read = 0;
        @(negedge clk);
        n_vec++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'h55AA55AA) begin n_err++; $display("FAIL rw_readback got v=%b d=%h want v=1 d=55aa55aa", bus.m0_readdatavalid, bus.m0_readdata); end
        tick();
    endtask

`ifdef MEM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        idle_inputs(); tick();
        bus.m0_read = 1; bus.m1_read = 1;
        for (int c = 0; c < 20; c++) begin
            bus.m0_address = ADDR_W'(c); bus.m1_address = ADDR_W'(c + 100);
            @(negedge clk);
            n_vec++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL fprio_c%0d got w0=%b w1=%b want 0 1", c, bus.m0_waitrequest, bus.m1_waitrequest); end
            tick();
        end
        bus.m0_read = 0;
        @(negedge clk);
        n_vec++; if (bus.m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL fprio_m1 got %b want 0", bus.m1_waitrequest); end
        tick(); idle_inputs(); tick();
    endtask
`else
    task automatic test_burst_fairness();
        int  m1_run = 0, m0_waits = 0;
        bit  m0_done = 0, finished = 0, g0, g1;
        idle_inputs(); tick();
        for (int c = 0; c < 40 && !finished; c++) begin
            bus.m1_read = 1; bus.m1_address = ADDR_W'(c + 32);
            bus.m0_read = (c >= 3) && !m0_done; bus.m0_address = 10'h064;
            @(negedge clk);
            g0 = bus.m0_read && !bus.m0_waitrequest;
            g1 = bus.m1_read && !bus.m1_waitrequest;
            if (!m0_done) begin
                if (g1) m1_run++;
                if (bus.m0_read && !g0) m0_waits++;
                if (g0) begin
                    m0_done = 1;
                    n_vec++; if (g1) begin n_err++; $display("FAIL burst_double_grant got g1=1 want 0"); end
                    n_vec++; if (m1_run != MAX_GRANT) begin n_err++; $display("FAIL burst_m1_run got %0d want %0d", m1_run, MAX_GRANT); end
                    n_vec++; if (m0_waits != MAX_GRANT - 3) begin n_err++; $display("FAIL burst_m0_wait got %0d want %0d", m0_waits, MAX_GRANT - 3); end
                end
            end else begin
                finished = 1;
                n_vec++; if (!g1) begin n_err++; $display("FAIL burst_m1_resume got 0 want 1"); end
            end
            tick();
        end
        n_vec++; if (!finished) begin n_err++; $display("FAIL burst_timeout got no m0 grant want grant within 40 cycles"); end
        idle_inputs(); tick();
    endtask
`endif

    task automatic test_reset_after_read();
        bus.m0_read = 1; bus.m0_address = 10'h005;
        tick(); bus.m0_read = 0; reset_n = 0;
        @(negedge clk);
        n_vec++; if (bus.m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_after_rd got %b want 0", bus.m0_readdatavalid); end
        tick(); reset_n = 1; tick();
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < 400; c++) begin
            op = (c >= 200) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 9));
            bus.m0_read = (op >= 4 && op <= 6) || op == 9; bus.m0_write = (op >= 7);
            op = (c >= 200) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 9));
            bus.m1_read = (op >= 4 && op <= 6) || op == 9; bus.m1_write = (op >= 7);
            bus.m0_address = ADDR_W'($urandom_range(0, 15)); bus.m1_address = ADDR_W'($urandom_range(0, 15));
            bus.m0_byteenable = BE_W'($urandom); bus.m1_byteenable = BE_W'($urandom);
            bus.m0_writedata = $urandom; bus.m1_writedata = $urandom;
            reset_n = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            n_vec++; if (bus.m0_waitrequest !== exp_w0 || bus.m1_waitrequest !== exp_w1) begin n_err++; $display("FAIL rnd_wait c%0d got %b%b want %b%b", c, bus.m0_waitrequest, bus.m1_waitrequest, exp_w0, exp_w1); end
            n_vec++; if (bus.mem_chipselect !== exp_cs || bus.mem_write !== exp_we) begin n_err++; $display("FAIL rnd_cs c%0d got cs=%b we=%b want cs=%b we=%b", c, bus.mem_chipselect, bus.mem_write, exp_cs, exp_we); end
            n_vec++; if (bus.mem_address !== exp_addr) begin n_err++; $display("FAIL rnd_addr c%0d got %h want %h", c, bus.mem_address, exp_addr); end
            if (exp_we) begin
                n_vec++; if (bus.mem_writedata !== sel_wd || bus.mem_byteenable !== sel_be) begin n_err++; $display("FAIL rnd_wdata c%0d got %h/%b want %h/%b", c, bus.mem_writedata, bus.mem_byteenable, sel_wd, sel_be); end
            end
            n_vec++; if (bus.m0_readdatavalid !== exp_rdv0 || bus.m1_readdatavalid !== exp_rdv1) begin n_err++; $display("FAIL rnd_rdv c%0d got %b%b want %b%b", c, bus.m0_readdatavalid, bus.m1_readdatavalid, exp_rdv0, exp_rdv1); end
            if (exp_rdv0 || exp_rdv1) begin
                n_vec++; if (bus.m0_readdata !== pend_data) begin n_err++; $display("FAIL rnd_rdata c%0d got %h want %h", c, bus.m0_readdata, pend_data); end
            end
            tick();
        end
        reset_n = 1; idle_inputs(); tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_rw_same();
`ifdef MEM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_burst_fairness();
`endif
        test_reset_after_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sm_mcu_mem_arbiter.md
Name: sm_mcu_mem_arbiter

Overview:
- Two-master arbiter sharing one single-port 1024x32 on-chip RAM (byte-enabled, 1-cycle read latency, address registered inside RAM, data unregistered) between the Nios data master (m0) and the TFT frame-fetch DMA (m1).
- Presents two Avalon-MM slave ports with waitrequest/readdatavalid; drives the RAM's address/byteenable/chipselect/write/writedata/clken.
- Round-robin with bounded burst ownership (MAX_GRANT), so the DMA cannot starve the CPU and vice versa.

Parameters:
- ADDR_W, 10, word address width (RAM depth 2^ADDR_W = 1024)
- DATA_W, 32, data width; byteenable width = DATA_W/8
- MAX_GRANT, 8, max consecutive transfers one master keeps ownership while the other is requesting (1..255)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for writes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  command not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data (mem_readdata fan-out)
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid for this master
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after read issue

Behaviour:
- req_x = mx_read | mx_write. Read+write both high on one port: write executes, read dropped, no readdatavalid.
- Grant is combinational from state and req; one command issued per cycle max. Granted master: waitrequest=0, mem_* driven from its port, mem_chipselect=1, mem_write=mx_write. Non-granted requester: waitrequest=1. Non-requester: waitrequest=0 (don't care).
- No grant: mem_chipselect=0, mem_write=0; mem_address/byteenable/writedata hold m0's values.
- State: IDLE, OWN0, OWN1; cnt (8 bit); last (owner of most recent grant).
- IDLE: only one requests -> grant it, go OWNx, cnt=1. Both -> grant master != last, go OWNx, cnt=1. None -> stay.
- OWNx: x requests and (cnt<MAX_GRANT or y idle) -> grant x, cnt=min(cnt+1,255). x requests, cnt>=MAX_GRANT, y requests -> grant y, OWNy, cnt=1. x idle, y requests -> grant y, OWNy, cnt=1. Neither -> IDLE, cnt=0.
- last updates on every grant.
- Read return: registered rd_pend and rd_owner set on a granted read. Next cycle mOwner_readdatavalid=1 for exactly one cycle. Back-to-back reads give back-to-back valids, possibly alternating owners. m0/m1_readdata = mem_readdata always.
- mem_clken = reset_n, so the RAM is frozen during reset.
- Reset (reset_n=0 at clk edge): state=IDLE, cnt=0, last=1 (m0 wins first tie), rd_pend=0. While reset_n=0, all waitrequest=1, mem_chipselect=0, mem_write=0, readdatavalid=0.
- Reset asserted the cycle after a read issue: the pending readdatavalid is suppressed.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: m0 always wins when both request, regardless of state, last or cnt. m1 is granted only when m0 is idle, and MAX_GRANT is ignored.
- Undefined: round-robin with MAX_GRANT bounded ownership as above.

Test Plan:
- Reset: hold reset_n=0 with both m0_read=1 and m1_read=1 -> m0/m1_waitrequest=1, mem_chipselect=0, no readdatavalid. Release with both still requesting -> m0 granted first.
- Single read: RAM preloaded addr 0x005=0xDEADBEEF, m1_read at 0x005 -> m1_waitrequest=0 that cycle, next cycle m1_readdatavalid=1 with 0xDEADBEEF, m0_readdatavalid=0.
- Byte write: m0_write addr 0x3FF, byteenable=0b0010, data 0x0000AB00 over 0x11223344 -> readback gives 0x1122AB44.
- Burst fairness, MAX_GRANT=8: m1 reads continuously, m0 requests from cycle 3 -> m1 gets 8 consecutive grants, then m0 is granted, then m1 resumes. m0 waitrequest high for at most 8 cycles.
- Simultaneous read+write on m0 at addr 0x010, data 0x55AA55AA -> memory written, no m0_readdatavalid next cycle.
- With MEM_ARB_FIXED_PRIO_EN: both request for 20 cycles -> all 20 grants go to m0, m1_waitrequest=1 throughout. m0 drops -> m1 granted the same cycle.
